// File: rtl/patch_memory_access_unit.sv
// Pops translated {addr, r_w, border} commands, performs single-port SRAM reads/writes,
// and returns {border, pixel} words. Optional macro ADDR_RANGE_CHECK_EN maps addr >= MEM_DEPTH to border.
module patch_memory_access_unit #(
   parameter int unsigned     ADDR_W       = 14,
   parameter int unsigned     PIX_W        = 8,
   parameter int unsigned     MEM_DEPTH    = 16384,
   parameter logic [PIX_W-1:0] BORDER_VALUE = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_pipe_read_ack,
   output logic                cmd_pipe_read_req,
   input  logic [ADDR_W+1:0]   cmd_pipe_read_data,
   input  logic                wdata_pipe_read_ack,
   output logic                wdata_pipe_read_req,
   input  logic [PIX_W-1:0]    wdata_pipe_read_data,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd_en,
   output logic                mem_wr_en,
   output logic [PIX_W-1:0]    mem_wdata,
   input  logic [PIX_W-1:0]    mem_rdata,
   output logic                data_pipe_write_req,
   input  logic                data_pipe_write_ack,
   output logic [PIX_W:0]      data_pipe_write_data,
   output logic                range_err
);

   typedef enum logic [2:0] {
      IDLE, DECODE, RD_ISSUE, RD_CAPT, WDATA, SEND
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   cmd_addr, cmd_addr_d;
   logic                cmd_rw, cmd_rw_d;
   logic                cmd_border, cmd_border_d;

   logic                cmd_req_d, wd_req_d, rd_en_d, wr_en_d, out_req_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [PIX_W-1:0]    wdata_d;
   logic [PIX_W:0]      out_data_d;
   logic                oob_c;
   logic                border_eff_c;
   logic                range_err_q, range_err_d;

`ifdef ADDR_RANGE_CHECK_EN
   assign oob_c     = (32'(cmd_addr) >= MEM_DEPTH);
   assign range_err = range_err_q;
`else
   logic [31:0] unused_mem_depth;
   assign unused_mem_depth = 32'(MEM_DEPTH);
   assign oob_c     = 1'b0;
   assign range_err = 1'b0;
`endif

   // Out-of-range addresses behave exactly like border pixels
   assign border_eff_c = cmd_border | oob_c;

   always_comb begin
      state_d      = state;
      cmd_addr_d   = cmd_addr;
      cmd_rw_d     = cmd_rw;
      cmd_border_d = cmd_border;
      cmd_req_d    = 1'b0;
      wd_req_d     = 1'b0;
      rd_en_d      = 1'b0;
      wr_en_d      = 1'b0;
      addr_d       = mem_addr;
      wdata_d      = mem_wdata;
      out_req_d    = data_pipe_write_req;
      out_data_d   = data_pipe_write_data;
      range_err_d  = range_err_q;

      case (state)
         IDLE: begin
            if (cmd_pipe_read_ack) begin
               cmd_addr_d   = cmd_pipe_read_data[ADDR_W+1:2];
               cmd_rw_d     = cmd_pipe_read_data[1];
               cmd_border_d = cmd_pipe_read_data[0];
               cmd_req_d    = 1'b1;
               state_d      = DECODE;
            end
         end
         DECODE: begin
            if (oob_c) range_err_d = 1'b1;
            if (!cmd_rw) begin
               state_d = WDATA;
            end else if (border_eff_c) begin
               out_data_d = {1'b1, BORDER_VALUE};
               out_req_d  = 1'b1;
               state_d    = SEND;
            end else begin
               addr_d  = cmd_addr;
               rd_en_d = 1'b1;
               state_d = RD_ISSUE;
            end
         end
         RD_ISSUE: state_d = RD_CAPT;
         RD_CAPT: begin
            out_data_d = {1'b0, mem_rdata};
            out_req_d  = 1'b1;
            state_d    = SEND;
         end
         WDATA: begin
            // Border writes still pop their data so the two pipes stay aligned
            if (wdata_pipe_read_ack) begin
               wd_req_d = 1'b1;
               if (!border_eff_c) begin
                  wr_en_d = 1'b1;
                  addr_d  = cmd_addr;
                  wdata_d = wdata_pipe_read_data;
               end
               state_d = IDLE;
            end
         end
         SEND: begin
            if (data_pipe_write_ack) begin
               out_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         cmd_addr             <= '0;
         cmd_rw               <= 1'b0;
         cmd_border           <= 1'b0;
         cmd_pipe_read_req    <= 1'b0;
         wdata_pipe_read_req  <= 1'b0;
         mem_addr             <= '0;
         mem_rd_en            <= 1'b0;
         mem_wr_en            <= 1'b0;
         mem_wdata            <= '0;
         data_pipe_write_req  <= 1'b0;
         data_pipe_write_data <= '0;
         range_err_q          <= 1'b0;
      end else begin
         state                <= state_d;
         cmd_addr             <= cmd_addr_d;
         cmd_rw               <= cmd_rw_d;
         cmd_border           <= cmd_border_d;
         cmd_pipe_read_req    <= cmd_req_d;
         wdata_pipe_read_req  <= wd_req_d;
         mem_addr             <= addr_d;
         mem_rd_en            <= rd_en_d;
         mem_wr_en            <= wr_en_d;
         mem_wdata            <= wdata_d;
         data_pipe_write_req  <= out_req_d;
         data_pipe_write_data <= out_data_d;
         range_err_q          <= range_err_d;
      end
   end

endmodule

// File: doc/patch_memory_access_unit.md
# patch_memory_access_unit

Downstream consumer of the address-translation stage in the Patch Memory Unit. Pops translated commands {address, r/w, border} from its input pipe and performs single-port SRAM reads and writes. Border pixels bypass memory and return a constant. Read results go to an output pipe toward the patch/pixel consumers.

## Interface
- ADDR_W, 14, SRAM address width; command word is ADDR_W+2 bits
- PIX_W, 8, pixel data width
- MEM_DEPTH, 16384, valid SRAM words; used only with range check
- BORDER_VALUE, 0, PIX_W-bit value returned for border pixels
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_pipe_read_ack  in  1  command available
- cmd_pipe_read_req  out  1  one-cycle pop pulse
- cmd_pipe_read_data  in  ADDR_W+2  {addr[ADDR_W-1:0], r_w, border}; r_w=1 read, 0 write
- wdata_pipe_read_ack  in  1  write data available
- wdata_pipe_read_req  out  1  one-cycle pop pulse
- wdata_pipe_read_data  in  PIX_W  write pixel
- mem_addr  out  ADDR_W  SRAM address
- mem_rd_en  out  1  SRAM read strobe; rdata valid the cycle after it is sampled
- mem_wr_en  out  1  SRAM write strobe
- mem_wdata  out  PIX_W  SRAM write data
- mem_rdata  in  PIX_W  SRAM read data
- data_pipe_write_req  out  1  output valid; held until accepted
- data_pipe_write_ack  in  1  output accepted
- data_pipe_write_data  out  PIX_W+1  {border, pixel}
- range_err  out  1  sticky out-of-range flag

## Operation
- FSM states: IDLE, DECODE, RD_ISSUE, RD_CAPT, WDATA, SEND. All outputs are registered.
- IDLE: if cmd_pipe_read_ack=1 at an edge, latch the command, pulse cmd_pipe_read_req for one cycle, and go to DECODE. Otherwise stay.
- DECODE, read with border=0: drive mem_addr, mem_rd_en=1, and go to RD_ISSUE.
- DECODE, read with border=1: load {1, BORDER_VALUE}, set data_pipe_write_req=1, and go to SEND. Memory is not touched.
- DECODE, r_w=0: go to WDATA.
- RD_ISSUE: drop mem_rd_en and go to RD_CAPT.
- RD_CAPT: load {0, mem_rdata}, set data_pipe_write_req=1, and go to SEND.
- WDATA: wait for wdata_pipe_read_ack=1. On that edge:
  - pulse wdata_pipe_read_req;
  - if border=0, drive mem_wr_en=1, mem_addr and mem_wdata for one cycle;
  - if border=1, discard the write data but still pop it, to keep the pipes aligned;
  - go to IDLE. Writes produce no output word.
- SEND: hold req and data stable. On an edge with data_pipe_write_ack=1, drop req and go to IDLE.
- Reset values: all outputs 0 and state IDLE. Reset mid-operation abandons the latched command and any pending output word; already-popped entries are lost.

## Timing
- Let E0 be the edge at which a command is accepted.
- Read: mem_rd_en is high during E1–E2, the SRAM samples at E2, data_pipe_write_req rises after E3.
- Border read: data_pipe_write_req rises after E1.
- Write: the earliest mem_wr_en cycle is E2–E3, when wdata is already available.
- Throughput: at most one command per 3 cycles (border), and per 5 cycles for a read with ack held high.
- No new command is accepted outside IDLE. A cmd ack that arrives in SEND waits until the IDLE cycle that follows.
- Accepting a new command requires a separate edge in IDLE: if SEND sees ack and a command is available at the same edge, the command is accepted one edge later.
- Pop pulses are exactly one cycle and never occur while their ack is low.
- Output back-pressure: data_pipe_write_ack may stay low indefinitely; data remains stable throughout.

## Configuration
- ADDR_RANGE_CHECK_EN defined: in DECODE, addr >= MEM_DEPTH is treated as border=1.
  - Reads return {1, BORDER_VALUE}; writes are dropped but wdata is popped.
  - range_err is set and stays high until reset.
- ADDR_RANGE_CHECK_EN undefined: no compare is made, addr is passed to mem_addr unchanged, and range_err is tied to 0.

## Test plan
- Preload SRAM[0x0105]=0xA7; push read cmd {0x0105, 1, 0} with output ack high -> one output word 0x0A7; data_pipe_write_req rises 3 edges after acceptance; exactly one cmd pop pulse.
- Push border read {0x0000, 1, 1} with BORDER_VALUE=0 -> output 0x100 after 1 edge; mem_rd_en never asserted.
- Push write cmd {0x0200, 0, 0}, then delay wdata=0x3C by 5 cycles -> the FSM stalls in WDATA; one mem_wr_en at addr 0x0200 with data 0x3C; readback returns 0x03C; no output word from the write.
- Hold data_pipe_write_ack low 10 cycles during a read -> req and data stay stable; no further cmd pop; after ack, the next queued command is accepted.
- Assert reset while in RD_CAPT -> all outputs 0 the next cycle; no output word; the FSM restarts cleanly on the next command.
- With ADDR_RANGE_CHECK_EN and MEM_DEPTH=8192, read {0x2000, 1, 0} -> output {1, BORDER_VALUE}; range_err=1 until reset. Without the macro, the same address is read from the SRAM and range_err=0.
